fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch controller that sits directly upstream of the branch predictor (BP).
- Owns the architectural fetch PC and issues one instruction-cache request at a time.
- Drives the BP with the fetched PC plus a predecoded branch flag, then consumes BP's registered next_pc, next_pc_valid and next_pc_index to choose the following PC.
- Fetched instructions, tagged with PC and OBQ index, are buffered in a small fetch queue feeding decode; an execute-stage mispredict redirects the PC and squashes the queue.

Parameters:
- FQ_DEPTH, 4, fetch-queue entries (power of 2, at least 2)
- OBQ_IDX_W, $clog2(`OBQ_SIZE)+1, width of the OBQ index carried per entry
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- icache_req_valid  out  1  fetch request valid
- icache_req_addr  out  32  fetch address, word aligned
- icache_req_ready  in  1  cache accepts the request this cycle
- icache_rsp_valid  in  1  response valid; at least 1 cycle after accept
- icache_rsp_inst  in  32  fetched instruction
- bp_pc  out  32  PC to BP pc_in
- bp_if_branch  out  1  predecoded conditional branch, pulse
- bp_next_pc_valid  in  1  BP prediction valid
- bp_next_pc  in  32  BP predicted next PC
- bp_next_pc_index  in  OBQ_IDX_W  BP OBQ index
- ex_mispredict  in  1  redirect request from execute
- ex_redirect_pc  in  32  corrected PC
- fq_valid  out  1  head entry valid
- fq_inst  out  32  head instruction
- fq_pc  out  32  head PC
- fq_obq_valid  out  1  head entry holds an OBQ index
- fq_obq_index  out  OBQ_IDX_W  head OBQ index
- dec_ready  in  1  decode pops the head when fq_valid is also high

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values:
  - pc = RESET_PC; state = S_REQ; queue empty.
  - Outputs: icache_req_valid=0, bp_if_branch=0, fq_valid=0, fq_obq_valid=0.
  - All data outputs are 0 during the reset cycle.
- Reset overrides everything, including ex_mispredict.
- States:
  - S_REQ: icache_req_valid=1 when fq_count<FQ_DEPTH, with addr=pc. On ready, go to S_WAIT.
  - S_WAIT: wait for icache_rsp_valid, then latch inst.
    - If is_cond_branch(inst): bp_pc=pc and bp_if_branch=1 in that same cycle; go to S_PRED.
    - Otherwise: push {inst, pc, obq_valid=0}; pc<=pc+4; go to S_REQ.
  - S_PRED: the BP registered result is sampled.
    - If bp_next_pc_valid: push {inst, pc, obq_valid=1, bp_next_pc_index}; pc<=bp_next_pc.
    - Else: push with obq_valid=0; pc<=pc+4.
    - Either way, go to S_REQ.
  - S_SQUASH: entered on a redirect while a response is outstanding. Wait for icache_rsp_valid, discard the response, then go to S_REQ.
- Latency: request accept to queue push is 1 cycle after the response for non-branches, 2 cycles for branches.
- Only one request is outstanding. Issuing only from S_REQ with count<FQ_DEPTH guarantees a slot for the push, because pops only free space.
- Queue:
  - Circular buffer; head/tail pointers carry an extra wrap bit.
  - fq_count = tail - head.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Head fields are driven combinationally from the entry at head.
- ex_mispredict has the highest priority after reset:
  - All entries are invalidated that cycle (head<=tail); a simultaneous pop or push is ignored.
  - pc <= ex_redirect_pc.
  - S_REQ or S_PRED go to S_REQ; the pending prediction is dropped and bp_if_branch is forced to 0.
  - S_WAIT with icache_rsp_valid=0 goes to S_SQUASH.
  - S_WAIT with icache_rsp_valid=1 drops the response and goes to S_REQ.
  - S_SQUASH stays in S_SQUASH with the new pc.
- A redirect issued in the same cycle a request is accepted goes to S_SQUASH, so the in-flight response is discarded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- bp_next_pc_valid is ignored outside S_PRED.

Decomposition:
- sys_defs.vh:
  - FETCH_STATE_T enum {S_REQ, S_WAIT, S_PRED, S_SQUASH}.
  - FQ_ENTRY_T struct {inst, pc, obq_valid, obq_index}.
  - is_cond_branch() predecode function.
- Sub-module fetch_queue: a parameterized FIFO of FQ_ENTRY_T with push, pop, flush, count, full and empty.

Test Plan:
- Reset, then cache ready=1 and rsp 1 cycle later, non-branch insts, dec_ready=1 -> requests at 0x0, 0x4, 0x8, each 2 cycles apart; fq_pc=0x0 then 0x4; fq_obq_valid=0.
- Branch at 0x10 with BP valid, next_pc=0x40, index=3 -> bp_if_branch pulses with bp_pc=0x10; entry {pc 0x10, obq_valid 1, index 3}; next request addr=0x40.
- Branch at 0x10 with bp_next_pc_valid=0 -> entry obq_valid=0; next addr=0x14.
- dec_ready=0 for 10 cycles -> exactly 4 entries, then icache_req_valid=0; a single pop re-enables the request the next cycle.
- ex_mispredict=1 with redirect 0x200 while in S_WAIT, response 2 cycles later -> fq_valid=0 the next cycle; response discarded; next request addr=0x200.
- ex_mispredict, a pop and a response all in the same cycle -> queue empty, response dropped, pc=redirect, state S_REQ.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types, sizes and predecode helper for the fetch controller
package fetch_ctrl_pkg;

    localparam int OBQ_SIZE      = 16;
    localparam int OBQ_IDX_WIDTH = $clog2(OBQ_SIZE) + 1;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_PRED,
        S_SQUASH
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]              inst;
        logic [31:0]              pc;
        logic                     obq_valid;
        logic [OBQ_IDX_WIDTH-1:0] obq_index;
    } fq_entry_t;

    // RISC-V B-type opcode: every conditional branch shares it
    function automatic logic is_cond_branch(input logic [31:0] inst);
        return inst[6:0] == 7'b1100011;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - icache, branch predictor, execute and decode signals of the fetch controller
interface fetch_ctrl_if #(
    parameter int OBQ_IDX_W = fetch_ctrl_pkg::OBQ_IDX_WIDTH
);
    logic                 icache_req_valid;
    logic [31:0]          icache_req_addr;
    logic                 icache_req_ready;
    logic                 icache_rsp_valid;
    logic [31:0]          icache_rsp_inst;
    logic [31:0]          bp_pc;
    logic                 bp_if_branch;
    logic                 bp_next_pc_valid;
    logic [31:0]          bp_next_pc;
    logic [OBQ_IDX_W-1:0] bp_next_pc_index;
    logic                 ex_mispredict;
    logic [31:0]          ex_redirect_pc;
    logic                 fq_valid;
    logic [31:0]          fq_inst;
    logic [31:0]          fq_pc;
    logic                 fq_obq_valid;
    logic [OBQ_IDX_W-1:0] fq_obq_index;
    logic                 dec_ready;

    modport master (
        output icache_req_valid, icache_req_addr, bp_pc, bp_if_branch,
               fq_valid, fq_inst, fq_pc, fq_obq_valid, fq_obq_index,
        input  icache_req_ready, icache_rsp_valid, icache_rsp_inst,
               bp_next_pc_valid, bp_next_pc, bp_next_pc_index,
               ex_mispredict, ex_redirect_pc, dec_ready
    );

    modport slave (
        input  icache_req_valid, icache_req_addr, bp_pc, bp_if_branch,
               fq_valid, fq_inst, fq_pc, fq_obq_valid, fq_obq_index,
        output icache_req_ready, icache_rsp_valid, icache_rsp_inst,
               bp_next_pc_valid, bp_next_pc, bp_next_pc_index,
               ex_mispredict, ex_redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetched entries with flush, wrap-bit pointers
module fetch_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fq_entry_t              head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [PW:0]   head;
    logic [PW:0]   tail;
    logic          do_push;
    logic          do_pop;

    // flush wins over any push or pop in the same cycle
    assign do_push   = push && !flush && !full;
    assign do_pop    = pop && !flush && !empty;
    assign count     = tail - head;
    assign full      = count == (PW + 1)'(DEPTH);
    assign empty     = head == tail;
    assign head_data = mem[head[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= tail;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC owner: one icache request in flight, BP handoff, fetch queue to decode
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          FQ_DEPTH  = 4,
    parameter int          OBQ_IDX_W = OBQ_IDX_WIDTH,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic          clock,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   inst_q;
    logic [CW-1:0] fq_count;
    logic          fq_full;
    logic          fq_empty;
    logic          push;
    logic          pop;
    logic          req_fire;
    logic          rsp_is_branch;
    fq_entry_t     push_data;
    fq_entry_t     head;

    assign rsp_is_branch        = is_cond_branch(bus.icache_rsp_inst);
    assign bus.icache_req_valid = !reset && state == S_REQ && fq_count < CW'(FQ_DEPTH);
    assign bus.icache_req_addr  = reset ? '0 : {pc[31:2], 2'b00};
    assign req_fire             = bus.icache_req_valid && bus.icache_req_ready;

    // BP registers pc_in on this pulse and answers during S_PRED
    assign bus.bp_if_branch = !reset && !bus.ex_mispredict && state == S_WAIT
                              && bus.icache_rsp_valid && rsp_is_branch;
    assign bus.bp_pc        = reset ? '0 : pc;

    always_comb begin
        push      = 1'b0;
        push_data = '0;
        push_data.pc = pc;
        if (!reset && !bus.ex_mispredict) begin
            if (state == S_WAIT && bus.icache_rsp_valid && !rsp_is_branch) begin
                push           = 1'b1;
                push_data.inst = bus.icache_rsp_inst;
            end else if (state == S_PRED) begin
                push                = 1'b1;
                push_data.inst      = inst_q;
                push_data.obq_valid = bus.bp_next_pc_valid;
                if (bus.bp_next_pc_valid)
                    push_data.obq_index = OBQ_IDX_WIDTH'(bus.bp_next_pc_index);
            end
        end
    end

    assign pop              = bus.fq_valid && bus.dec_ready;
    assign bus.fq_valid     = !reset && !fq_empty;
    assign bus.fq_inst      = reset ? '0 : head.inst;
    assign bus.fq_pc        = reset ? '0 : head.pc;
    assign bus.fq_obq_valid = bus.fq_valid && head.obq_valid;
    assign bus.fq_obq_index = reset ? '0 : OBQ_IDX_W'(head.obq_index);

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.ex_mispredict),
        .head_data (head),
        .count     (fq_count),
        .full      (fq_full),
        .empty     (fq_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            inst_q <= '0;
        end else if (bus.ex_mispredict) begin
            pc <= bus.ex_redirect_pc;
            case (state)
                S_REQ:    state <= req_fire ? S_SQUASH : S_REQ;
                S_WAIT:   state <= bus.icache_rsp_valid ? S_REQ : S_SQUASH;
                // a response landing with the redirect is the one being squashed
                S_SQUASH: state <= bus.icache_rsp_valid ? S_REQ : S_SQUASH;
                default:  state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: if (req_fire) state <= S_WAIT;
                S_WAIT: begin
                    if (bus.icache_rsp_valid) begin
                        inst_q <= bus.icache_rsp_inst;
                        if (rsp_is_branch) begin
                            state <= S_PRED;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= S_REQ;
                        end
                    end
                end
                S_PRED: begin
                    pc    <= bus.bp_next_pc_valid ? bus.bp_next_pc : pc + 32'd4;
                    state <= S_REQ;
                end
                default: if (bus.icache_rsp_valid) state <= S_REQ;
            endcase
        end
    end

    a_push_has_room: assert property (@(posedge clock) disable iff (reset) push |-> !fq_full);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl against a program-walk model
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int W = OBQ_IDX_WIDTH;

    typedef struct {
        logic [31:0]  inst;
        logic [31:0]  pc;
        bit           obqv;
        logic [W-1:0] idx;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_ctrl_if #(.OBQ_IDX_W(W)) bus ();

    fetch_ctrl #(.FQ_DEPTH(4), .OBQ_IDX_W(W), .RESET_PC(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0]  mem    [256];
    bit           is_br  [256];
    bit           bp_v   [256];
    logic [31:0]  bp_tgt [256];
    logic [W-1:0] bp_ix  [256];

    exp_t        exp_q[$];
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    int          cyc = 0;
    bit          ready_rand = 0;
    bit          delay_rand = 0;
    logic [31:0] last_rsp_addr = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_acc(input int i, input logic [31:0] addr, input string name);
        if (i < acc_addr.size()) check(name, acc_addr[i], addr);
        else begin
            checks++;
            errors++;
            $display("FAIL %s: request %0d never issued, expected addr %0h", name, i, addr);
        end
    endtask

    function automatic logic [31:0] make_inst(input bit br);
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], br ? 7'b1100011 : 7'b0010011};
    endfunction

    // expected decode stream: straight-line walk of the program, following valid predictions
    function automatic void push_walk(input logic [31:0] start, input int n);
        logic [31:0] pc;
        int          w;
        exp_t        e;
        pc = start;
        for (int k = 0; k < n; k++) begin
            w      = int'(pc[9:2]);
            e.inst = mem[w];
            e.pc   = pc;
            e.obqv = is_br[w] && bp_v[w];
            e.idx  = bp_ix[w];
            exp_q.push_back(e);
            pc = e.obqv ? bp_tgt[w] : pc + 32'd4;
        end
    endfunction

    task automatic redirect(input logic [31:0] t);
        @(posedge clock); #1;
        bus.ex_mispredict  = 1'b1;
        bus.ex_redirect_pc = t;
        exp_q.delete();
        push_walk(t, 48);
        @(posedge clock); #1;
        bus.ex_mispredict  = 1'b0;
        bus.ex_redirect_pc = $urandom;
    endtask

    // icache and branch-predictor environment
    initial begin : env
        bit          acc;
        bit          br;
        bit          pending;
        int          cnt;
        int          w;
        logic [31:0] a;
        logic [31:0] out_addr;
        pending = 0;
        cnt = 0;
        out_addr = '0;
        bus.icache_req_ready = 1'b0;
        bus.icache_rsp_valid = 1'b0;
        bus.icache_rsp_inst  = '0;
        bus.bp_next_pc_valid = 1'b0;
        bus.bp_next_pc       = '0;
        bus.bp_next_pc_index = '0;
        forever begin
            @(negedge clock);
            acc = bus.icache_req_valid && bus.icache_req_ready;
            a   = bus.icache_req_addr;
            br  = bus.bp_if_branch;
            if (br) begin
                check("bp_pc", bus.bp_pc, last_rsp_addr);
                check("bp_pulse_on_branch", 64'(is_br[last_rsp_addr[9:2]]), 64'd1);
            end
            if (acc) begin
                check("one_outstanding", 64'(pending), 64'd0);
                pending  = 1;
                out_addr = a;
                cnt      = delay_rand ? $urandom_range(0, 2) : 0;
                acc_addr.push_back(a);
                acc_cyc.push_back(cyc);
            end
            @(posedge clock); #1;
            if (br) begin
                w = int'(last_rsp_addr[9:2]);
                bus.bp_next_pc_valid = bp_v[w];
                bus.bp_next_pc       = bp_tgt[w];
                bus.bp_next_pc_index = bp_ix[w];
            end else begin
                bus.bp_next_pc_valid = 1'($urandom);
                bus.bp_next_pc       = $urandom;
                bus.bp_next_pc_index = W'($urandom);
            end
            bus.icache_rsp_valid = 1'b0;
            bus.icache_rsp_inst  = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    bus.icache_rsp_valid = 1'b1;
                    bus.icache_rsp_inst  = mem[out_addr[9:2]];
                    last_rsp_addr        = out_addr;
                    pending              = 0;
                end else begin
                    cnt--;
                end
            end
            bus.icache_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // scoreboard monitor: every accepted pop is compared against the model stream
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.fq_valid && bus.dec_ready && !bus.ex_mispredict) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fq_extra: got pc %0h with no expected entry", bus.fq_pc);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    check("fq_pc", bus.fq_pc, e.pc);
                    check("fq_inst", bus.fq_inst, e.inst);
                    check("fq_obq_valid", 64'(bus.fq_obq_valid), 64'(e.obqv));
                    if (e.obqv) check("fq_obq_index", 64'(bus.fq_obq_index), 64'(e.idx));
                end
            end
        end
    end

    initial begin : driver
        int i0;
        logic [31:0] t;
        for (int i = 0; i < 256; i++) begin
            is_br[i]  = $urandom_range(0, 3) == 0;
            mem[i]    = make_inst(is_br[i]);
            bp_v[i]   = 1'($urandom);
            bp_tgt[i] = $urandom & ~32'h3;
            bp_ix[i]  = W'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            is_br[i] = 0;
            mem[i]   = make_inst(0);
        end
        is_br[4] = 1; mem[4] = make_inst(1); bp_v[4] = 1; bp_tgt[4] = 32'h40; bp_ix[4] = W'(3);
        is_br[7] = 1; mem[7] = make_inst(1); bp_v[7] = 1; bp_tgt[7] = 32'hFFFF_FFFC;
        is_br[32] = 1; mem[32] = make_inst(1); bp_v[32] = 0;
        is_br[255] = 0; mem[255] = make_inst(0);

        reset              = 1'b1;
        bus.ex_mispredict  = 1'b1;
        bus.ex_redirect_pc = 32'h300;
        bus.dec_ready      = 1'b1;
        @(negedge clock);
        check("rst_req_valid", 64'(bus.icache_req_valid), 64'd0);
        check("rst_bp_if_branch", 64'(bus.bp_if_branch), 64'd0);
        check("rst_fq_valid", 64'(bus.fq_valid), 64'd0);
        check("rst_fq_obq_valid", 64'(bus.fq_obq_valid), 64'd0);
        check("rst_req_addr", bus.icache_req_addr, 64'd0);
        check("rst_fq_inst", bus.fq_inst, 64'd0);
        @(posedge clock); @(posedge clock); #1;
        reset             = 1'b0;
        bus.ex_mispredict = 1'b0;
        push_walk(32'h0, 48);

        repeat (30) @(posedge clock);
        #1;
        check_acc(0, 32'h0, "first_req_addr");
        check_acc(1, 32'h4, "second_req_addr");
        check_acc(2, 32'h8, "third_req_addr");
        check_acc(5, 32'h40, "predicted_target_addr");
        if (acc_cyc.size() >= 6) begin
            check("req_gap_01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
            check("req_gap_12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
            check("req_gap_branch", 64'(acc_cyc[5] - acc_cyc[4]), 64'd3);
        end

        redirect(32'h80);
        i0 = acc_addr.size();
        repeat (20) @(posedge clock);
        #1;
        check_acc(i0, 32'h80, "redirect_req_addr");
        check_acc(i0 + 1, 32'h84, "bp_invalid_falls_through");

        ready_rand = 1;
        delay_rand = 1;
        for (int s = 0; s < 25; s++) begin
            repeat ($urandom_range(15, 50)) begin
                @(posedge clock); #1;
                bus.dec_ready = $urandom_range(0, 3) != 0;
            end
            t = $urandom & ~32'h3;
            if (s % 6 == 0) t = 32'hFFFF_FFFC;
            redirect(t);
        end

        ready_rand = 0;
        delay_rand = 0;
        repeat (4) @(posedge clock);
        #1;
        bus.dec_ready = 1'b0;
        redirect(32'h100);
        repeat (40) @(posedge clock);
        @(negedge clock);
        check("full_blocks_req", 64'(bus.icache_req_valid), 64'd0);
        check("full_fq_valid", 64'(bus.fq_valid), 64'd1);
        @(posedge clock); #1;
        bus.dec_ready = 1'b1;
        @(posedge clock); #1;
        bus.dec_ready = 1'b0;
        @(negedge clock);
        check("pop_reenables_req", 64'(bus.icache_req_valid), 64'd1);
        @(posedge clock); #1;
        bus.ex_mispredict  = 1'b1;
        bus.ex_redirect_pc = 32'hFFFF_FFFC;
        bus.dec_ready      = 1'b1;
        exp_q.delete();
        push_walk(32'hFFFF_FFFC, 48);
        @(negedge clock);
        check("collide_rsp_valid", 64'(bus.icache_rsp_valid), 64'd1);
        check("collide_fq_valid", 64'(bus.fq_valid), 64'd1);
        @(posedge clock); #1;
        bus.ex_mispredict = 1'b0;
        i0 = acc_addr.size();
        @(negedge clock);
        check("flushed_fq_valid", 64'(bus.fq_valid), 64'd0);
        repeat (30) @(posedge clock);
        #1;
        check_acc(i0, 32'hFFFF_FFFC, "collide_redirect_addr");
        check_acc(i0 + 1, 32'h0, "pc_wraps_to_zero");
        check("progress", 64'(popped >= 60), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
